// File: rtl/debug_probe_sel_pkg.sv
// Shared encodings for the debug probe selector: display modes and trigger FSM states.
package debug_probe_sel_pkg;

  typedef enum logic [1:0] {
    ModeLive    = 2'b00,
    ModeScan    = 2'b01,
    ModeTrig    = 2'b10,
    ModeLiveAlt = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StArmed  = 2'b01,
    StFrozen = 2'b10
  } trig_state_e;

endpackage

// File: rtl/debug_probe_sel_probe_mux.sv
// Combinational NUM_CH:1 binary-select mux over a packed probe bus; out-of-range selects read 0.
module debug_probe_sel_probe_mux #(
  parameter int   NUM_CH = 8,
  parameter int   DATA_W = 32,
  localparam int  SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH*DATA_W-1:0] probe_bus,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        data
);

  always_comb begin
    data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(sel) == k) data = probe_bus[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/debug_probe_sel.sv
// Debug probe selector: LIVE selection, SCAN auto-rotation and TRIG snapshot capture,
// all outputs registered one cycle after the inputs.
module debug_probe_sel
  import debug_probe_sel_pkg::*;
#(
  parameter int  NUM_CH   = 8,
  parameter int  DATA_W   = 32,
  parameter int  SCAN_DIV = 50000000,
  localparam int SEL_W    = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH*DATA_W-1:0] probe_bus,
  input  logic [SEL_W-1:0]         sel,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         trig_ch,
  input  logic [DATA_W-1:0]        trig_value,
  input  logic                     trig_arm,
  output logic [DATA_W-1:0]        result,
  output logic [SEL_W-1:0]         cur_ch,
  output logic                     armed,
  output logic                     frozen
);

  localparam int CNT_W = $clog2(SCAN_DIV) + 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(SCAN_DIV - 1);

  logic [DATA_W-1:0] result_q;
  logic [SEL_W-1:0]  cur_ch_q;
  logic              armed_q, frozen_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  trig_state_e       state_q;
  logic [DATA_W-1:0] snap_q [NUM_CH];

  logic              is_scan, is_trig, cnt_wrap, trig_hit;
  logic [SEL_W-1:0]  scan_ch, live_sel;
  logic [DATA_W-1:0] live_data, trig_data, snap_data;

  assign is_scan = (mode == ModeScan);
  assign is_trig = (mode == ModeTrig);

  // SCAN shows the channel after a possible advance, so the mux sees the next cur_ch.
  always_comb begin
    cnt_wrap = (cnt_q == CntMax);
    cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    if (!cnt_wrap) begin
      scan_ch = cur_ch_q;
    end else if (int'(cur_ch_q) >= NUM_CH - 1) begin
      scan_ch = '0;
    end else begin
      scan_ch = cur_ch_q + SEL_W'(1);
    end
  end

  assign live_sel = is_scan ? scan_ch : sel;

  debug_probe_sel_probe_mux #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) u_live_mux (
    .probe_bus (probe_bus),
    .sel       (live_sel),
    .data      (live_data)
  );

  debug_probe_sel_probe_mux #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) u_trig_mux (
    .probe_bus (probe_bus),
    .sel       (trig_ch),
    .data      (trig_data)
  );

  // The mux returns 0 for an out-of-range trig_ch, so range must gate the match explicitly.
  assign trig_hit = (int'(trig_ch) < NUM_CH) && (trig_data == trig_value);

  always_comb begin
    snap_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(sel) == k) snap_data = snap_q[k];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_q <= '0;
      cur_ch_q <= '0;
      armed_q  <= 1'b0;
      frozen_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= StIdle;
      for (int k = 0; k < NUM_CH; k++) snap_q[k] <= '0;
    end else if (is_scan) begin
      cnt_q    <= cnt_d;
      cur_ch_q <= scan_ch;
      result_q <= live_data;
      state_q  <= StIdle;
      armed_q  <= 1'b0;
      frozen_q <= 1'b0;
    end else begin
      cnt_q <= '0;
      if (is_trig && state_q == StFrozen) begin
        result_q <= snap_data;
        cur_ch_q <= sel;
        if (trig_arm) begin
          state_q  <= StArmed;
          armed_q  <= 1'b1;
          frozen_q <= 1'b0;
        end
      end else begin
        result_q <= live_data;
        cur_ch_q <= sel;
        if (!is_trig) begin
          state_q  <= StIdle;
          armed_q  <= 1'b0;
          frozen_q <= 1'b0;
        end else if (state_q == StIdle) begin
          if (trig_arm) begin
            state_q <= StArmed;
            armed_q <= 1'b1;
          end
        end else if (trig_hit) begin
          for (int k = 0; k < NUM_CH; k++) snap_q[k] <= probe_bus[k*DATA_W +: DATA_W];
          state_q  <= StFrozen;
          armed_q  <= 1'b0;
          frozen_q <= 1'b1;
        end
      end
    end
  end

  assign result = result_q;
  assign cur_ch = cur_ch_q;
  assign armed  = armed_q;
  assign frozen = frozen_q;

endmodule

// File: tb/tb_debug_probe_sel.sv
// Randomised and directed bench for debug_probe_sel against a behavioural cycle model.
module tb_debug_probe_sel;

  localparam int NumCh   = 8;
  localparam int DataW   = 32;
  localparam int ScanDiv = 4;
  localparam int SelW    = 3;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic [NumCh*DataW-1:0]  probe_bus;
  logic [SelW-1:0]         sel, trig_ch;
  logic [1:0]              mode;
  logic [DataW-1:0]        trig_value;
  logic                    trig_arm;
  logic [DataW-1:0]        result;
  logic [SelW-1:0]         cur_ch;
  logic                    armed, frozen;

  logic [31:0] probe  [NumCh];
  logic [31:0] m_snap [NumCh];
  logic [31:0] m_res;
  int          m_ch, m_cnt, m_st;  // m_st: 0 idle, 1 waiting for match, 2 holding snapshot
  int          n_tests = 0;
  int          n_fail  = 0;

  debug_probe_sel #(
    .NUM_CH   (NumCh),
    .DATA_W   (DataW),
    .SCAN_DIV (ScanDiv)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .probe_bus  (probe_bus),
    .sel        (sel),
    .mode       (mode),
    .trig_ch    (trig_ch),
    .trig_value (trig_value),
    .trig_arm   (trig_arm),
    .result     (result),
    .cur_ch     (cur_ch),
    .armed      (armed),
    .frozen     (frozen)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NumCh; k++) probe_bus[k*DataW +: DataW] = probe[k];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ch  = 0;
    m_cnt = 0;
    m_st  = 0;
    m_res = '0;
    for (int k = 0; k < NumCh; k++) m_snap[k] = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int m, s;
    m = (int'(mode) == 3) ? 0 : int'(mode);
    s = int'(sel);
    if (m == 1) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == ScanDiv) begin
        m_cnt = 0;
        m_ch  = (m_ch + 1) % NumCh;
      end
      m_res = probe[m_ch];
      m_st  = 0;
    end else begin
      m_cnt = 0;
      m_ch  = s;
      if (m == 2 && m_st == 2) begin
        m_res = m_snap[s];
        if (trig_arm) m_st = 1;
      end else begin
        m_res = (s < NumCh) ? probe[s] : 32'h0;
        if (m != 2) begin
          m_st = 0;
        end else if (m_st == 0) begin
          if (trig_arm) m_st = 1;
        end else if (int'(trig_ch) < NumCh && probe[trig_ch] == trig_value) begin
          for (int k = 0; k < NumCh; k++) m_snap[k] = probe[k];
          m_st = 2;
        end
      end
    end
  endtask

  task automatic check_all();
    check_val("result", result, m_res);
    check_val("cur_ch", 32'(cur_ch), 32'(m_ch));
    check_val("armed", 32'(armed), 32'(m_st == 1));
    check_val("frozen", 32'(frozen), 32'(m_st == 2));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic bump_probes();
    for (int k = 0; k < NumCh; k++) if (k != 2) probe[k] = probe[k] + 32'h100;
  endtask

  initial begin
    resetn     = 1'b0;
    mode       = 2'b00;
    sel        = '0;
    trig_ch    = '0;
    trig_value = '0;
    trig_arm   = 1'b0;
    for (int k = 0; k < NumCh; k++) probe[k] = 32'h1000_0000 + 32'(k);
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    resetn = 1'b1;

    // LIVE selection
    sel = 3'd3;
    cycle();
    check_val("live_sel3", result, 32'h1000_0003);
    sel = 3'd6;
    cycle();

    // SCAN: entry keeps cur_ch=6, 10 advances over 40 cycles
    mode = 2'b01;
    repeat (40) cycle();
    check_val("scan40_ch", 32'(cur_ch), 32'd0);
    check_val("scan40_res", result, 32'h1000_0000);

    // TRIG: arm, then ramp ch2 to the trigger value
    mode = 2'b10; sel = 3'd0; trig_ch = 3'd2; trig_value = 32'd5;
    cycle();
    trig_arm = 1'b1;
    cycle();
    trig_arm = 1'b0;
    check_val("armed_after_arm", 32'(armed), 32'd1);
    for (int v = 0; v < 8; v++) begin
      probe[2] = 32'(v);
      bump_probes();
      cycle();
      if (v == 5) check_val("frozen_on_match", 32'(frozen), 32'd1);
    end
    for (int s = 0; s < NumCh; s++) begin
      sel = 3'(s);
      bump_probes();
      probe[2] = probe[2] + 32'd1;
      cycle();
      if (s == 2) check_val("snap_ch2", result, 32'd5);
    end

    // Re-arm, then arm pulse coinciding with a match
    trig_arm = 1'b1;
    cycle();
    check_val("rearm_frozen", 32'(frozen), 32'd0);
    probe[2] = 32'd5;
    cycle();
    trig_arm = 1'b0;
    check_val("arm_and_match", 32'(frozen), 32'd1);

    // Asynchronous reset while frozen, between clock edges
    #2;
    resetn = 1'b0;
    #1;
    check_val("async_rst_res", result, 32'h0);
    check_val("async_rst_frz", 32'(frozen), 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    mode = 2'b00;
    sel = 3'd6;
    cycle();
    check_val("post_rst_live", result, probe[6]);

    // Leave TRIG while armed; return without arming must not capture
    mode = 2'b10;
    trig_arm = 1'b1;
    probe[2] = 32'd9;
    cycle();
    trig_arm = 1'b0;
    mode = 2'b00;
    cycle();
    check_val("leave_trig_armed", 32'(armed), 32'd0);
    mode = 2'b10;
    probe[2] = 32'd5;
    repeat (3) cycle();
    check_val("no_capture_idle", 32'(frozen), 32'd0);

    // Randomised traffic with small values so triggers actually fire
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      sel        = 3'($urandom_range(0, NumCh - 1));
      trig_ch    = 3'($urandom_range(0, NumCh - 1));
      trig_value = 32'($urandom_range(0, 7));
      trig_arm   = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < NumCh; k++) begin
        if ($urandom_range(0, 1) == 0) probe[k] = 32'($urandom_range(0, 7));
        else if ($urandom_range(0, 3) == 0) probe[k] = $urandom;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
